// File: rtl/draw_board_anim.sv
// ---------------------------------------------------------------------------
// draw_board_anim
//   Board renderer for the 2048 VGA path. Maps the beam position (x,y) to an
//   RRGGBB pixel for an NxN board of power-of-2 sized cells, through a fixed
//   two-stage registered pipeline (pixel for inputs at cycle t appears at t+2).
//   The grid is snapshotted only on frame_tick, so a frame never tears. A
//   small frame-driven FSM fades newly spawned tiles over FADE_FRAMES frames.
//
// Ports
//   clk            pixel clock
//   rst_n          asynchronous active-low reset
//   grid           N*N cell values, cell k=(row*N+col) at [k*VAL_W +: VAL_W]
//   new_tiles      per-cell new-tile mask, captured with new_tiles_load
//   new_tiles_load one-cycle request to fade the cells in new_tiles
//   frame_tick     one-cycle pulse at start of vertical blank
//   x, y           beam position
//   video_active   beam inside the visible area
//   retro_colors   palette select
//   rrggbb         registered pixel colour
//   fade_busy      registered, high while a fade is pending or running
// ---------------------------------------------------------------------------
module draw_board_anim #(
  parameter int N           = 4,
  parameter int CELL_LOG2   = 6,
  parameter int VAL_W       = 4,
  parameter int BOARD_X     = 192,
  parameter int BOARD_Y     = 128,
  parameter int FADE_FRAMES = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*N*VAL_W-1:0] grid,
  input  logic [N*N-1:0]       new_tiles,
  input  logic                 new_tiles_load,
  input  logic                 frame_tick,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 video_active,
  input  logic                 retro_colors,
  output logic [5:0]           rrggbb,
  output logic                 fade_busy
);

  localparam int NL    = $clog2(N);
  localparam int IDX_W = 2 * NL;
  localparam int CELLS = N * N;
  // Bits of a board-relative coordinate that lie beyond the board extent.
  localparam int HI_LO = CELL_LOG2 + NL;

  localparam logic [10:0] BX0      = 11'(BOARD_X);
  localparam logic [10:0] BY0      = 11'(BOARD_Y);
  localparam logic [2:0]  FADE_CNT = 3'(FADE_FRAMES);
  localparam logic [CELL_LOG2-1:0] LOC_MAX = {CELL_LOG2{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FADING  = 2'd2
  } state_t;

  // Glyph generator: the cell is viewed as an 8x8 raster; a 4x4 block in the
  // middle carries the glyph. Top and bottom rows are bars, the middle rows
  // light one column per bit of the value. Value 0 is an empty cell.
  function automatic logic draw_numbers(input logic [VAL_W-1:0]     idx,
                                        input logic [CELL_LOG2-1:0] lx,
                                        input logic [CELL_LOG2-1:0] ly);
    logic [2:0] gx;
    logic [2:0] gy;
    logic [1:0] col;
    logic [3:0] v4;
    gx  = lx[CELL_LOG2-1 -: 3];
    gy  = ly[CELL_LOG2-1 -: 3];
    col = 2'(gx - 3'd2);
    v4  = 4'(idx);
    draw_numbers = (idx != '0) &&
                   (gx >= 3'd2) && (gx <= 3'd5) &&
                   (gy >= 3'd2) && (gy <= 3'd5) &&
                   ((gy == 3'd2) || (gy == 3'd5) || v4[col]);
  endfunction

  // Fade FSM and frame snapshot state
  state_t                 state_q;
  logic                   busy_q;
  logic [N*N*VAL_W-1:0]   grid_q;
  logic [CELLS-1:0]       mask_q;
  logic [CELLS-1:0]       pend_q;
  logic [2:0]             cnt_q;

  logic [CELLS-1:0]       req_s;
  logic                   start_s;

  // Stage-1 pipeline registers
  logic [VAL_W-1:0]       val_q;
  logic                   new_q;
  logic                   inb_q;
  logic                   outl_q;
  logic                   x0_q;
  logic                   act_q;
  logic                   retro_q;
  logic [CELL_LOG2-1:0]   lx_q;
  logic [CELL_LOG2-1:0]   ly_q;

  logic [10:0]            bx_s;
  logic [10:0]            by_s;
  logic [IDX_W-1:0]       idx_s;
  logic                   inb_s;
  logic                   outl_s;
  logic [VAL_W-1:0]       val_s;
  logic                   new_s;

  logic [5:0]             rgb_d;
  logic [5:0]             rgb_q;

  // A fade starts at a tick if a request is pending or arrives in that same
  // cycle; a same-cycle load wins over the stale pending mask.
  always_comb begin
    req_s   = new_tiles_load ? new_tiles : pend_q;
    start_s = frame_tick && (new_tiles_load || (state_q == ST_PENDING));
  end

  // Fade FSM with grid/mask snapshot; fade_busy registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      grid_q  <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= 3'd0;
    end else begin
      if (frame_tick) begin
        grid_q <= grid;
      end
      if (start_s) begin
        if (req_s != '0) begin
          mask_q  <= req_s;
          cnt_q   <= FADE_CNT;
          state_q <= ST_FADING;
          busy_q  <= 1'b1;
        end else begin
          mask_q  <= '0;
          cnt_q   <= 3'd0;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end else if (frame_tick && (state_q == ST_FADING)) begin
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          mask_q  <= '0;
          cnt_q   <= 3'd0;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end else if (new_tiles_load) begin
        // Leaves mask/cnt untouched: a running fade freezes until the tick.
        pend_q  <= new_tiles;
        state_q <= ST_PENDING;
        busy_q  <= 1'b1;
      end
    end
  end

  // Stage-1 decode: board-relative position, cell lookup, outline flag.
  // x < BOARD_X borrows into bit 10; x >= BOARD_X + board width sets a bit
  // above the board extent. Either way the high bits are non-zero.
  always_comb begin
    bx_s   = {1'b0, x} - BX0;
    by_s   = {1'b0, y} - BY0;
    inb_s  = (bx_s[10:HI_LO] == '0) && (by_s[10:HI_LO] == '0);
    idx_s  = {by_s[CELL_LOG2 +: NL], bx_s[CELL_LOG2 +: NL]};
    val_s  = grid_q[idx_s*VAL_W +: VAL_W];
    new_s  = mask_q[idx_s];
    outl_s = (bx_s[CELL_LOG2-1:0] == '0) || (bx_s[CELL_LOG2-1:0] == LOC_MAX) ||
             (by_s[CELL_LOG2-1:0] == '0) || (by_s[CELL_LOG2-1:0] == LOC_MAX);
  end

  // Stage-1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q   <= '0;
      new_q   <= 1'b0;
      inb_q   <= 1'b0;
      outl_q  <= 1'b0;
      x0_q    <= 1'b0;
      act_q   <= 1'b0;
      retro_q <= 1'b0;
      lx_q    <= '0;
      ly_q    <= '0;
    end else begin
      val_q   <= val_s;
      new_q   <= new_s;
      inb_q   <= inb_s;
      outl_q  <= outl_s;
      x0_q    <= x[0];
      act_q   <= video_active;
      retro_q <= retro_colors;
      lx_q    <= bx_s[CELL_LOG2-1:0];
      ly_q    <= by_s[CELL_LOG2-1:0];
    end
  end

  // Stage-2 colour priority: blank, glyph, outline, background
  always_comb begin
    rgb_d = 6'b000000;
    if (!act_q || !inb_q) begin
      rgb_d = 6'b000000;
    end else if (draw_numbers(val_q, lx_q, ly_q)) begin
      if (new_q) begin
        rgb_d = 6'b001111 ^ {3'b000, cnt_q};
      end else begin
        rgb_d = retro_q ? 6'b101110 : 6'b001111;
      end
    end else if (outl_q) begin
      rgb_d = retro_q ? 6'b001000 : 6'b111111;
    end else begin
      rgb_d = retro_q ? {3'b000, x0_q, 2'b00} : 6'b000000;
    end
  end

  // Stage-2 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 6'b000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rrggbb    = rgb_q;
  assign fade_busy = busy_q;

endmodule
